watchdog_pio_in_edge: RTL and testbench
=======================================

Name: watchdog_pio_in_edge

Overview:
- Parametrised Avalon-MM input PIO slave for the watchdog CPU system; the successor to the single-bit ENABLE input port.
- Synchronises a WIDTH-bit asynchronous input bus and exposes its level at offset 0.
- Adds per-bit edge capture, a per-bit interrupt mask and a level-sensitive IRQ to the CPU.
- Sits between board inputs (switches, ultrasonic echo/status lines) and the Avalon interconnect.

Parameters:
- WIDTH, 8, number of input bits (1..32).
- SYNC_STAGES, 2, synchroniser flops per bit (2..4).
- EDGE_TYPE, 0, edge that sets a capture bit: 0 = rising, 1 = falling, 2 = any.
- IRQ_EN, 1, 1 = irq driven from capture & mask; 0 = irq tied 0 and irqmask reads 0.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous active-high reset.
- address  in  2  word offset: 0 data, 1 reserved, 2 irqmask, 3 edgecapture.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe; write when chipselect=1 and write_n=0.
- writedata  in  32  write data; bits above WIDTH ignored.
- in_port  in  WIDTH  asynchronous external inputs.
- readdata  out  32  registered read data; bits above WIDTH read 0.
- irq  out  1  level interrupt to the CPU.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on reset; everything is sampled on the rising edge of clk.
- Reset values: readdata=0, irqmask=0, edgecapture=0, all synchroniser flops 0, prev=0, prime counter=0, irq=0.
- Synchroniser: each in_port bit passes through SYNC_STAGES flops. The output is sync_q.
- Edge detect:
  - prev <= sync_q every cycle.
  - rise = sync_q & ~prev; fall = ~sync_q & prev; edge is selected by EDGE_TYPE.
- Priming:
  - A counter counts 0..SYNC_STAGES+1 after reset and then saturates.
  - Edge detect is gated off until the counter saturates.
  - Inputs held high through reset therefore produce no spurious capture.
  - Reset asserted mid-operation restarts priming.
- Latency: an in_port change is visible in sync_q after SYNC_STAGES clocks. The capture bit sets on the following clock, and irq asserts combinationally from the registered capture and mask.
- edgecapture:
  - bit i sets on a detected edge.
  - A write to offset 3 clears every bit where writedata[i]=1.
  - Simultaneous edge and clear on the same bit: set wins, so the bit stays 1.
  - Bits not written as 1 are unaffected.
- irqmask: a write to offset 2 loads writedata[WIDTH-1:0].
- Offset 1: reads 0; writes ignored.
- Offset 0: writes ignored.
- readdata:
  - Registered every cycle from the currently presented address, independent of chipselect, giving 1-cycle read latency.
  - Offset 0 returns sync_q.
  - A write and a read of the same register in one cycle return the pre-write value.
- irq = IRQ_EN ? |(edgecapture & irqmask) : 0. No extra registering; glitch-free because it is derived only from flops.
- Widths: all internal vectors are WIDTH bits, zero-extended to 32 on readdata.

Decomposition:
- Package watchdog_pio_pkg holds:
  - address constants PIO_ADDR_DATA=0, PIO_ADDR_RSVD=1, PIO_ADDR_IRQMASK=2, PIO_ADDR_EDGECAP=3;
  - EDGE_RISING=0, EDGE_FALLING=1, EDGE_ANY=2;
  - the Avalon data width constant 32.
- One sub-module, pio_sync_chain: parametrised WIDTH×SYNC_STAGES synchroniser with synchronous reset to 0. Edge detect, priming, registers and read mux stay in the top module.

Test Plan (WIDTH=8, SYNC_STAGES=2, EDGE_TYPE=0, IRQ_EN=1 unless stated):
1. in_port=8'hA5 held through reset release, no writes. Expect:
   - read offset 0 returns 32'h000000A5 once synchronised;
   - edgecapture stays 0 after priming;
   - irq=0.
2. Write irqmask=8'h0F, then drive in_port bit 2 0→1. Expect:
   - edgecapture=8'h04 exactly 3 clocks after the in_port change;
   - irq=1 the same cycle;
   - readdata reflects the new value one clock after address=3 is presented.
3. With edgecapture=8'h04, write 32'h00000004 to offset 3. Expect edgecapture=0 and irq=0 on the next clock. Writing 32'hFFFFFF00 leaves the low bits unchanged.
4. Time a rising edge on bit 0 to reach detect in the same cycle as a clear write 32'h1 to offset 3. Expect edgecapture[0]=1.
5. EDGE_TYPE=2, toggle bit 7 high then low, clearing between the two edges. Expect capture after each edge. With EDGE_TYPE=1, only the high→low edge captures.
6. Capture 8'h81, then assert reset for one cycle while in_port=8'hFF. Expect:
   - all registers and irq = 0;
   - no capture during priming;
   - offset 0 reads 32'hFF after synchronisation.

Source files
------------

// File: rtl/watchdog_pio_pkg.sv
// Shared constants for the watchdog input PIO:
// Avalon register offsets, edge selections and bus width.
package watchdog_pio_pkg;

    localparam int AV_DW = 32;

    localparam logic [1:0] PIO_ADDR_DATA    = 2'd0;
    localparam logic [1:0] PIO_ADDR_RSVD    = 2'd1;
    localparam logic [1:0] PIO_ADDR_IRQMASK = 2'd2;
    localparam logic [1:0] PIO_ADDR_EDGECAP = 2'd3;

    localparam int EDGE_RISING  = 0;
    localparam int EDGE_FALLING = 1;
    localparam int EDGE_ANY     = 2;

endpackage

// File: rtl/pio_sync_chain.sv
// WIDTH x SYNC_STAGES flop synchroniser for asynchronous inputs,
// synchronous active-high reset to zero.
module pio_sync_chain #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_async,
    output logic [WIDTH-1:0] sync_q
);

    logic [WIDTH-1:0] stage_q [SYNC_STAGES];
    logic [WIDTH-1:0] stage_d [SYNC_STAGES];

    always_comb begin
        stage_d[0] = in_async;
        for (int k = 1; k < SYNC_STAGES; k++) begin
            stage_d[k] = stage_q[k-1];
        end
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < SYNC_STAGES; k++) begin
            if (reset) begin
                stage_q[k] <= '0;
            end else begin
                stage_q[k] <= stage_d[k];
            end
        end
    end

    assign sync_q = stage_q[SYNC_STAGES-1];

endmodule

// File: rtl/watchdog_pio_in_edge.sv
// Avalon-MM input PIO: synchronised level, per-bit edge capture,
// interrupt mask and level IRQ for the watchdog CPU.
module watchdog_pio_in_edge
    import watchdog_pio_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_TYPE   = 0,
    parameter int IRQ_EN      = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    localparam logic [2:0] PRIME_MAX = 3'(SYNC_STAGES + 1);

    logic [WIDTH-1:0] sync_q;
    logic [WIDTH-1:0] prev_q, prev_d;
    logic [2:0]       prime_q, prime_d;
    logic [WIDTH-1:0] irqmask_q, irqmask_d;
    logic [WIDTH-1:0] edgecap_q, edgecap_d;
    logic [AV_DW-1:0] readdata_q, readdata_d;

    logic             wr_en;
    logic             primed;
    logic [WIDTH-1:0] wdata;
    logic [WIDTH-1:0] rise, fall, edge_sel, edge_det, clr;
    logic             unused_wd;

    pio_sync_chain #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk      (clk),
        .reset    (reset),
        .in_async (in_port),
        .sync_q   (sync_q)
    );

    assign unused_wd = ^writedata;

    always_comb begin
        wdata  = writedata[WIDTH-1:0];
        wr_en  = chipselect & ~write_n;
        primed = (prime_q == PRIME_MAX);
        rise   = sync_q & ~prev_q;
        fall   = ~sync_q & prev_q;

        if (EDGE_TYPE == EDGE_RISING) begin
            edge_sel = rise;
        end else if (EDGE_TYPE == EDGE_FALLING) begin
            edge_sel = fall;
        end else begin
            edge_sel = rise | fall;
        end

        // The chain comes out of reset at 0; hold off detection
        // until it and prev both reflect the real inputs.
        edge_det = primed ? edge_sel : '0;
        prime_d  = primed ? prime_q : prime_q + 3'd1;
        prev_d   = sync_q;

        irqmask_d = irqmask_q;
        if (IRQ_EN != 0 && wr_en && address == PIO_ADDR_IRQMASK) begin
            irqmask_d = wdata;
        end

        clr = '0;
        if (wr_en && address == PIO_ADDR_EDGECAP) begin
            clr = wdata;
        end
        edgecap_d = (edgecap_q & ~clr) | edge_det;

        readdata_d = '0;
        unique case (address)
            PIO_ADDR_DATA:    readdata_d[WIDTH-1:0] = sync_q;
            PIO_ADDR_IRQMASK: readdata_d[WIDTH-1:0] = irqmask_q;
            PIO_ADDR_EDGECAP: readdata_d[WIDTH-1:0] = edgecap_q;
            default:          readdata_d = '0;
        endcase

        irq = (IRQ_EN != 0) && (|(edgecap_q & irqmask_q));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prev_q     <= '0;
            prime_q    <= '0;
            irqmask_q  <= '0;
            edgecap_q  <= '0;
            readdata_q <= '0;
        end else begin
            prev_q     <= prev_d;
            prime_q    <= prime_d;
            irqmask_q  <= irqmask_d;
            edgecap_q  <= edgecap_d;
            readdata_q <= readdata_d;
        end
    end

    assign readdata = readdata_q;

endmodule

// File: tb/tb_watchdog_pio_in_edge.sv
// Directed bench for watchdog_pio_in_edge: rising-edge main instance
// plus any-edge and falling-edge instances on a shared bus.
module tb_watchdog_pio_in_edge;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [7:0]  in_port;
    logic [31:0] rd_main, rd_any, rd_fall;
    logic        irq_main, irq_any, irq_fall;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    watchdog_pio_in_edge #(
        .WIDTH(8), .SYNC_STAGES(2), .EDGE_TYPE(0), .IRQ_EN(1)
    ) u_dut (
        .clk(clk), .reset(reset), .address(address),
        .chipselect(chipselect), .write_n(write_n),
        .writedata(writedata), .in_port(in_port),
        .readdata(rd_main), .irq(irq_main)
    );

    watchdog_pio_in_edge #(
        .WIDTH(8), .SYNC_STAGES(2), .EDGE_TYPE(2), .IRQ_EN(1)
    ) u_any (
        .clk(clk), .reset(reset), .address(address),
        .chipselect(chipselect), .write_n(write_n),
        .writedata(writedata), .in_port(in_port),
        .readdata(rd_any), .irq(irq_any)
    );

    watchdog_pio_in_edge #(
        .WIDTH(8), .SYNC_STAGES(2), .EDGE_TYPE(1), .IRQ_EN(1)
    ) u_fall (
        .clk(clk), .reset(reset), .address(address),
        .chipselect(chipselect), .write_n(write_n),
        .writedata(writedata), .in_port(in_port),
        .readdata(rd_fall), .irq(irq_fall)
    );

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        tick();
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
    endtask

    task automatic rd(input logic [1:0] a);
        address = a;
        tick();
    endtask

    initial begin
        reset      = 1'b1;
        address    = 2'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        in_port    = 8'hA5;
        @(negedge clk);
        tick(2);
        chk("rst_rdata", rd_main, 32'h0);
        chk("rst_irq", {31'b0, irq_main}, 32'h0);
        reset = 1'b0;

        // 1: inputs high through reset, no spurious capture
        tick(5);
        rd(2'd0);
        chk("t1_data", rd_main, 32'h000000A5);
        rd(2'd3);
        chk("t1_edgecap", rd_main, 32'h0);
        chk("t1_irq", {31'b0, irq_main}, 32'h0);
        rd(2'd1);
        chk("t1_rsvd", rd_main, 32'h0);

        // 2: mask and rising edge on bit 2
        wr(2'd2, 32'h0000000F);
        rd(2'd2);
        chk("t2_mask", rd_main, 32'h0000000F);
        in_port = 8'hA1;
        tick(4);
        address = 2'd3;
        tick();
        in_port = 8'hA5;
        tick(2);
        chk("t2_irq_early", {31'b0, irq_main}, 32'h0);
        tick();
        chk("t2_irq", {31'b0, irq_main}, 32'h1);
        chk("t2_rd_lag", rd_main, 32'h0);
        tick();
        chk("t2_edgecap", rd_main, 32'h00000004);

        // 3: write-one-to-clear, high bits ignored
        wr(2'd3, 32'h00000004);
        chk("t3_irq_clr", {31'b0, irq_main}, 32'h0);
        rd(2'd3);
        chk("t3_clr", rd_main, 32'h0);
        in_port = 8'hA0;
        tick(4);
        in_port = 8'hA5;
        tick(4);
        wr(2'd3, 32'hFFFFFF00);
        rd(2'd3);
        chk("t3_hi_clr", rd_main, 32'h00000005);
        chk("t3_irq", {31'b0, irq_main}, 32'h1);
        wr(2'd0, 32'h000000FF);
        wr(2'd1, 32'h000000FF);
        rd(2'd0);
        chk("t3_data_ro", rd_main, 32'h000000A5);
        wr(2'd3, 32'h00000005);
        rd(2'd3);
        chk("t3_clr2", rd_main, 32'h0);

        // 4: edge detect and clear in the same cycle
        in_port = 8'hA4;
        tick(4);
        in_port = 8'hA5;
        tick(2);
        wr(2'd3, 32'h00000001);
        rd(2'd3);
        chk("t4_set_wins", rd_main, 32'h00000001);
        wr(2'd3, 32'h00000001);
        rd(2'd3);
        chk("t4_clr", rd_main, 32'h0);

        // 5: any-edge and falling-edge instances on bit 7
        in_port = 8'h25;
        tick(4);
        wr(2'd3, 32'h000000FF);
        in_port = 8'hA5;
        tick(4);
        rd(2'd3);
        chk("t5_any_rise", rd_any, 32'h00000080);
        chk("t5_fall_rise", rd_fall, 32'h0);
        chk("t5_main_rise", rd_main, 32'h00000080);
        wr(2'd3, 32'h000000FF);
        in_port = 8'h25;
        tick(4);
        rd(2'd3);
        chk("t5_any_fall", rd_any, 32'h00000080);
        chk("t5_fall_fall", rd_fall, 32'h00000080);
        chk("t5_main_fall", rd_main, 32'h0);

        // 6: capture 0x81 then reset with inputs all high
        in_port = 8'h24;
        tick(4);
        wr(2'd3, 32'h000000FF);
        wr(2'd2, 32'h00000081);
        in_port = 8'hA5;
        tick(4);
        rd(2'd3);
        chk("t6_cap", rd_main, 32'h00000081);
        chk("t6_irq", {31'b0, irq_main}, 32'h1);
        reset   = 1'b1;
        in_port = 8'hFF;
        tick();
        reset = 1'b0;
        chk("t6_rst_rd", rd_main, 32'h0);
        chk("t6_rst_irq", {31'b0, irq_main}, 32'h0);
        rd(2'd2);
        chk("t6_mask", rd_main, 32'h0);
        tick(4);
        rd(2'd3);
        chk("t6_prime", rd_main, 32'h0);
        chk("t6_any_prime", rd_any, 32'h0);
        rd(2'd0);
        chk("t6_data", rd_main, 32'h000000FF);
        chk("t6_irq_end", {31'b0, irq_main}, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
